pwm_capture16: RTL and testbench
================================

// Module: pwm_capture16
// PURPOSE
// - Receiving end of a PWM link: measures high time and period of an asynchronous
//   PWM input in clk cycles. Each completed period yields one high_cnt/period_cnt
//   pair and a one-cycle valid strobe.
// - Sits between a PWM source (e.g. a pwm16 output looped back or from an external
//   board) and register/readout logic; with WIDTH=16 and the same clock,
//   high_cnt equals the generator's duty value.
// PARAMETERS
// - WIDTH        16  counter/result width; maximum measurable period 2**WIDTH cycles
// - SYNC_STAGES  2   flip-flops in the pwm_in synchronizer, >= 2
// PORTS
// - clk         in   1      system clock, all logic on posedge
// - rst_n       in   1      asynchronous reset, active low
// - pwm_in      in   1      PWM input, asynchronous to clk
// - high_cnt    out  WIDTH  high cycles of last complete period, saturates at all-ones
// - period_cnt  out  WIDTH  (period cycles - 1) of last complete period
// - valid       out  1      one-cycle strobe when high_cnt/period_cnt update
// - stuck_hi    out  1      input held high >= 2**WIDTH cycles; sticky until next valid measurement
// - stuck_lo    out  1      input held low >= 2**WIDTH cycles, or no rising edge since reset
// BEHAVIOUR
// - Reset (async, rst_n=0): sync chain=0, state=ACQ, counters=0, all outputs=0.
// - Input path: SYNC_STAGES synchronizer, then 1 register for edge detect.
//   rise = s & ~s_d, fall = ~s & s_d. Latency pin->edge = SYNC_STAGES+1 cycles.
// - FSM:
//   - ACQ: discard partial period. On rise -> HIGH; pcnt=0, hcnt=1.
//   - HIGH: pcnt++, hcnt++ (saturating). On fall -> LOW.
//   - LOW: pcnt++. On rise -> publish, then restart pcnt=0, hcnt=1, -> HIGH.
// - Publish, same cycle as the rise:
//   - high_cnt <= hcnt; period_cnt <= pcnt; valid <= 1 on the next cycle only;
//     stuck_hi/stuck_lo <= 0.
//   - Registered outputs hold between publishes.
// - Counting: pcnt is the cycle count since the last rise, minus 1.
//   - Example: a 65536-cycle period with WIDTH=16 reports period_cnt=16'hFFFF.
//   - A 1-cycle high pulse reports high_cnt=1.
// - Timeout: pcnt==all-ones and no rise this cycle.
//   - In HIGH: stuck_hi<=1; high_cnt, period_cnt <= all-ones.
//   - In LOW or ACQ: stuck_lo<=1; high_cnt<=0; period_cnt<=all-ones.
//   - valid pulses once per timeout event; FSM -> ACQ; stuck flag holds.
//   - ACQ timeout is armed from reset; the first rise in ACQ re-arms it.
// - Edge cases:
//   - Fall and rise never coincide (post-sync edges are >=1 cycle apart).
//   - A rise in HIGH cannot occur.
//   - hcnt never exceeds pcnt+1.
//   - A glitch shorter than 1 clk may be missed; this is accepted.
//   - Reset asserted mid-period aborts the measurement; no valid is emitted.
//   - Output width: results truncate to WIDTH only via saturation; no wrap.
// STRUCTURE
// - Package pwm_pkg: typedef enum logic [1:0] {ACQ, HIGH, LOW} cap_state_t;
//   localparam PWM_WIDTH=16 shared with pwm16.
// - Sub-module sync_edge (parameter SYNC_STAGES): clk, rst_n, d -> level, rise, fall.
// - Top: FSM, two counters and output registers.
// TESTING
// - Same-clock pwm16 loopback, val=16'h4000 -> after first full period: high_cnt=16'h4000,
//   period_cnt=16'hFFFF, valid once per 65536 cycles.
// - 10-cycle period, 3 high -> high_cnt=3, period_cnt=9, valid every 10 cycles after the
//   first partial period.
// - pwm_in constant 0 from reset -> stuck_lo=1, high_cnt=0, period_cnt=16'hFFFF, single
//   valid after 65536 cycles; then 5-high/5-low input -> stuck_lo=0, high_cnt=5, period_cnt=9.
// - pwm_in rises and then stays 1 -> stuck_hi=1, high_cnt=period_cnt=16'hFFFF; release ->
//   FSM reacquires, next full period valid.
// - rst_n pulsed low mid-HIGH -> outputs 0 immediately (async); first valid only after a
//   complete new period.
// - 1-cycle-high, 2-cycle period -> high_cnt=1, period_cnt=1, valid every 2 cycles.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair.
// Provides the capture FSM state type and the default PWM counter width.
package pwm_pkg;

  localparam int PWM_WIDTH = 16;

  typedef enum logic [1:0] {
    ACQ,
    HIGH,
    LOW
  } cap_state_t;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous input and flags its edges.
// Ports: clk, rst_n (async, active low), d (async input),
//        level (synchronized d), rise/fall (one-cycle edge flags).
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], d};
      level_d <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/pwm_capture16.sv
// Measures high time and period of an asynchronous PWM input in clk cycles.
// Ports: clk, rst_n (async, active low), pwm_in (async), high_cnt,
//        period_cnt (period-1), valid (strobe), stuck_hi, stuck_lo.
module pwm_capture16
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_cnt,
  output logic [WIDTH-1:0] period_cnt,
  output logic             valid,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam logic [WIDTH-1:0] ONES = '1;

  cap_state_t       state;
  logic [WIDTH-1:0] pcnt;
  logic [WIDTH-1:0] hcnt;
  logic             armed;
  logic             level;
  logic             rise;
  logic             fall;
  logic             tmo;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pwm_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  assign tmo = (pcnt == ONES) && !rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACQ;
      pcnt       <= '0;
      hcnt       <= '0;
      armed      <= 1'b1;
      high_cnt   <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        ACQ: begin
          if (rise) begin
            state <= HIGH;
            pcnt  <= '0;
            hcnt  <= WIDTH'(1);
            armed <= 1'b1;
          end else if (armed) begin
            // One timeout report per silent stretch; a rise re-arms it.
            if (tmo) begin
              stuck_lo   <= 1'b1;
              high_cnt   <= '0;
              period_cnt <= ONES;
              valid      <= 1'b1;
              armed      <= 1'b0;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
        end
        HIGH: begin
          if (tmo) begin
            stuck_hi   <= 1'b1;
            high_cnt   <= ONES;
            period_cnt <= ONES;
            valid      <= 1'b1;
            armed      <= 1'b0;
            state      <= ACQ;
          end else begin
            pcnt <= pcnt + 1'b1;
            // The falling cycle itself is low, so it is not high time.
            if (level && hcnt != ONES) hcnt <= hcnt + 1'b1;
            if (fall) state <= LOW;
          end
        end
        LOW: begin
          if (rise) begin
            high_cnt   <= hcnt;
            period_cnt <= pcnt;
            valid      <= 1'b1;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
            pcnt       <= '0;
            hcnt       <= WIDTH'(1);
            state      <= HIGH;
          end else if (tmo) begin
            stuck_lo   <= 1'b1;
            high_cnt   <= '0;
            period_cnt <= ONES;
            valid      <= 1'b1;
            armed      <= 1'b0;
            state      <= ACQ;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: state <= ACQ;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture16.sv
// Self-checking bench for pwm_capture16 with a reduced WIDTH.
// Expected publishes come from segment lengths fed into a queue.
module tb_pwm_capture16;

  localparam int W    = 10;
  localparam int FULL = 1 << W;
  localparam logic [W-1:0] ONES = '1;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] high_cnt;
  logic [W-1:0] period_cnt;
  logic         valid;
  logic         stuck_hi;
  logic         stuck_lo;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vcyc     = 0;
  int rel      = 0;

  typedef struct {
    logic [W-1:0] hc;
    logic [W-1:0] pc;
    logic         sh;
    logic         sl;
  } exp_t;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int hc;
    int pc;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[7];

  pwm_capture16 #(
    .WIDTH      (W),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .high_cnt  (high_cnt),
    .period_cnt(period_cnt),
    .valid     (valid),
    .stuck_hi  (stuck_hi),
    .stuck_lo  (stuck_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid) begin
      vcyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: hc=%0d pc=%0d sh=%b sl=%b",
                 high_cnt, period_cnt, stuck_hi, stuck_lo);
      end else begin
        e = exp_q.pop_front();
        if (high_cnt !== e.hc || period_cnt !== e.pc ||
            stuck_hi !== e.sh || stuck_lo !== e.sl) begin
          failures++;
          $display("FAIL publish: got hc=%0d pc=%0d sh=%b sl=%b want hc=%0d pc=%0d sh=%b sl=%b",
                   high_cnt, period_cnt, stuck_hi, stuck_lo,
                   e.hc, e.pc, e.sh, e.sl);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input int hc, input int pc,
                      input logic sh, input logic sl);
    exp_t e;
    e.hc = W'(hc);
    e.pc = W'(pc);
    e.sh = sh;
    e.sl = sl;
    exp_q.push_back(e);
  endtask

  task automatic periods(input int hi, input int lo, input int reps);
    repeat (reps) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
    hold(1'b1, 1);
  endtask

  task automatic drain(input string nm);
    hold(1'b0, 8);
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int h;
    int l;

    tbl[0] = '{3, 7, 4, 3, 9};
    tbl[1] = '{1, 1, 6, 1, 1};
    tbl[2] = '{5, 5, 3, 5, 9};
    tbl[3] = '{1, FULL-1, 2, 1, FULL-1};
    tbl[4] = '{FULL-1, 1, 2, FULL-1, FULL-1};
    tbl[5] = '{64, 192, 3, 64, 255};
    tbl[6] = '{2, 1, 5, 2, 2};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_high_cnt", high_cnt, 0);
    chk("rst_period_cnt", period_cnt, 0);
    chk("rst_valid", valid, 0);
    chk("rst_stuck_hi", stuck_hi, 0);
    chk("rst_stuck_lo", stuck_lo, 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      hold(1'b0, 10);
      repeat (tbl[i].reps) push(tbl[i].hc, tbl[i].pc, 1'b0, 1'b0);
      periods(tbl[i].hi, tbl[i].lo, tbl[i].reps);
      drain($sformatf("tbl%0d_count", i));
    end

    // Silent input from reset: one timeout exactly FULL cycles in.
    do_reset();
    rel = cyc;
    push(0, FULL-1, 1'b0, 1'b1);
    hold(1'b0, FULL + 10);
    chk("lo_time", vcyc - rel, FULL);
    drain("lo_count");
    chk("lo_flag", stuck_lo, 1);
    hold(1'b0, FULL);
    chk("lo_hold", stuck_lo, 1);
    chk("lo_high_cnt", high_cnt, 0);
    chk("lo_period_cnt", period_cnt, ONES);
    repeat (3) push(5, 9, 1'b0, 1'b0);
    periods(5, 5, 3);
    drain("lo_recover");
    chk("lo_clear", stuck_lo, 0);

    // Input stuck high after a rise, then released.
    do_reset();
    push(FULL-1, FULL-1, 1'b1, 1'b0);
    hold(1'b0, 5);
    hold(1'b1, FULL + 20);
    drain("hi_count");
    chk("hi_flag", stuck_hi, 1);
    repeat (3) push(3, 9, 1'b0, 1'b0);
    hold(1'b0, 4);
    periods(3, 7, 3);
    drain("hi_recover");
    chk("hi_clear", stuck_hi, 0);

    // Reset in the middle of a high phase.
    do_reset();
    hold(1'b0, 10);
    push(3, 9, 1'b0, 1'b0);
    hold(1'b1, 3);
    hold(1'b0, 7);
    hold(1'b1, 6);
    chk("mid_before", exp_q.size(), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_high_cnt", high_cnt, 0);
    chk("mid_period_cnt", period_cnt, 0);
    chk("mid_valid", valid, 0);
    chk("mid_stuck", {stuck_hi, stuck_lo}, 0);
    pwm_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 5);
    repeat (2) push(4, 9, 1'b0, 1'b0);
    periods(4, 6, 2);
    drain("mid_recover");

    // Random legal periods against the segment-length model.
    do_reset();
    hold(1'b0, $urandom_range(1, 20));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        h = $urandom_range(1, FULL - 1);
        l = $urandom_range(1, FULL - h);
      end else begin
        h = $urandom_range(1, 30);
        l = $urandom_range(1, 30);
      end
      push(h, h + l - 1, 1'b0, 1'b0);
      hold(1'b1, h);
      hold(1'b0, l);
    end
    hold(1'b1, 1);
    drain("rand_count");
    chk("rand_stuck", {stuck_hi, stuck_lo}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
